// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cmp_ctrl_fulladder.sv
// Single-bit full adder; the comparator time-shares one instance across all operand bits.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial a-vs-b comparator: computes a - b LSB first through one full adder.
// Define SERIAL_CMP_SIGNED_EN for two's-complement comparison (default is unsigned).
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_greater_b,
    output logic             a_equal_b,
    output logic             a_smaller_b,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic              zero_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              gt_q;
    logic              eq_q;
    logic              lt_q;
    logic              gt_d;
    logic              eq_d;
    logic              lt_d;
    logic              fa_sum;
    logic              fa_cout;

`ifdef SERIAL_CMP_SIGNED_EN
    logic              cin_msb_q;
    logic              msb_sum_q;
    logic              overflow;
`endif

    // Subtraction as a + ~b + 1: the +1 comes from the carry preset at accept.
    fulladder u_fa (
        .a    (a_q[0]),
        .b    (~b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

`ifdef SERIAL_CMP_SIGNED_EN
    always_comb begin
        overflow = cin_msb_q ^ carry_q;
        lt_d     = msb_sum_q ^ overflow;
        eq_d     = zero_q;
        gt_d     = ~lt_d & ~zero_q;
    end
`else
    always_comb begin
        gt_d = carry_q & ~zero_q;
        eq_d = zero_q;
        lt_d = ~carry_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
            cin_msb_q   <= 1'b0;
            msb_sum_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= 1'b1;
                        zero_q     <= 1'b1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= fa_cout;
                    if (fa_sum) begin
                        zero_q <= 1'b0;
                    end
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_CMP_SIGNED_EN
                        cin_msb_q <= carry_q;
                        msb_sum_q <= fa_sum;
`endif
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the flags; they then hold until taken.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        gt_q        <= gt_d;
                        eq_q        <= eq_d;
                        lt_q        <= lt_d;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        gt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign a_greater_b = gt_q;
    assign a_equal_b   = eq_q;
    assign a_smaller_b = lt_q;

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have in_valid  input  1  operand pair a/b presented.
REQ-005 SHALL have in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have a  input  WIDTH  first operand.
REQ-007 SHALL have b  input  WIDTH  second operand.
REQ-008 SHALL have out_valid  output  1  result flags valid.
REQ-009 SHALL have out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have a_greater_b, a_equal_b, a_smaller_b  output  1 each  one-hot compare result.
REQ-011 SHALL have busy  output  1  high while in RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, latch a and b into shift registers, set carry=1, zero_flag=1, bit counter=0, go to RUN.
REQ-014 RUN: each cycle, feed a[i], ~b[i] and carry through one shared full adder (a - b, LSB first); update carry; clear zero_flag if sum bit is 1; shift; increment counter.
REQ-015 RUN SHALL last exactly WIDTH cycles, then go to DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-016 DONE, unsigned: a_greater_b = carry & ~zero_flag; a_equal_b = zero_flag; a_smaller_b = ~carry.
REQ-017 DONE: out_valid=1; flags held stable until out_valid&out_ready, then go to IDLE the next cycle.
REQ-018 in_ready SHALL be 0 in RUN and DONE; in_valid outside IDLE is ignored and operands are not re-sampled.
REQ-019 Result flags SHALL be exactly one-hot while out_valid=1 and all 0 otherwise.
REQ-020 Operands SHALL be unmodified by a, b changes after the accept edge.
REQ-021 Counter SHALL be $clog2(WIDTH+1) bits; no wrap-around is permitted within RUN.

Reset
REQ-022 rst=1 SHALL force IDLE on the next edge from any state, including mid-RUN; the in-flight comparison is discarded.
REQ-023 Reset values: in_ready=1 (after reset deasserts), out_valid=0, busy=0, all result flags 0, carry=0, counter=0, shift registers 0.

Configuration
REQ-024 Macro SERIAL_CMP_SIGNED_EN SHALL select two's-complement comparison.
REQ-025 With SERIAL_CMP_SIGNED_EN: record the carry into the MSB; overflow = carry_into_msb ^ carry_out; a_smaller_b = msb_sum ^ overflow; a_equal_b = zero_flag; a_greater_b = ~a_smaller_b & ~zero_flag.
REQ-026 Without SERIAL_CMP_SIGNED_EN: unsigned rules of REQ-016; no MSB/overflow registers are synthesised.

Structure
REQ-027 Shared package serial_cmp_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 SHALL instantiate the existing fulladder once as its only sub-module; no other arithmetic.

Verification (WIDTH=8)
REQ-029 a=5, b=3 accepted at cycle 0 -> out_valid at cycle 9, greater=1, equal=0, smaller=0.
REQ-030 a=b=0xAA -> equal=1 only; then a=255, b=0 -> greater=1 only.
REQ-031 a=0x00, b=0xFF -> smaller=1 unsigned; with SERIAL_CMP_SIGNED_EN, greater=1 (0 > -1); a=0x80, b=0x7F signed -> smaller=1.
REQ-032 out_ready low for 5 cycles in DONE -> flags and out_valid stable, in_ready=0, new in_valid ignored; IDLE one cycle after the out_ready handshake.
REQ-033 rst pulsed during RUN bit 3 -> IDLE next cycle, out_valid=0, flags 0; a fresh a=1, b=2 compare then gives smaller=1 with normal latency.
